nf_keypad_scan: RTL and testbench

- Time-multiplexed matrix keypad scanner: the input-side counterpart of the dynamic seven-segment driver.
- Drives one row of the keypad low at a time and samples the active-low columns.
- Debounces whole-matrix snapshots and reports new key presses as a code plus a one-cycle strobe.
- Sits on the board top beside the seven-segment driver; its outputs feed a GPIO input port of the SoC.

---
 rtl/nf_keypad_scan.sv | 181 ++++++++++++++++++
 tb/tb_nf_keypad_scan.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/nf_keypad_scan.sv
// Matrix keypad scanner: one-cold row drive, synchronized column sense, debounced key map and press strobe.
// Optional macro NF_KEYPAD_RELEASE_EN adds key_release / key_rel_code outputs.
module nf_keypad_scan #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEB_CNT  = 4,
  localparam int KW      = $clog2(ROWS*COLS)
) (
  input  logic                 clk,
  input  logic                 resetn,
  output logic [ROWS-1:0]      row_o,
  input  logic [COLS-1:0]      col_i,
  output logic [ROWS*COLS-1:0] key_map,
  output logic [KW-1:0]        key_code,
  output logic                 key_press,
  output logic                 key_any,
  output logic                 key_multi
`ifdef NF_KEYPAD_RELEASE_EN
  ,
  output logic                 key_release,
  output logic [KW-1:0]        key_rel_code
`endif
);

  localparam int N  = ROWS*COLS;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int RW = $clog2(ROWS);
  localparam int SW = $clog2(DEB_CNT+1);

  typedef enum logic {ST_SCAN, ST_EVAL} state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_presc, w_presc_nxt;
  logic [RW-1:0]   r_row, w_row_nxt;
  logic [ROWS-1:0] r_row_o;
  logic [COLS-1:0] r_col_m, r_col_s;
  logic [N-1:0]    r_snap, r_prev, r_key_map;
  logic [SW-1:0]   r_stable, w_stable_nxt;
  logic [KW-1:0]   r_key_code;
  logic            r_key_press, r_key_any, r_key_multi;
  logic            w_term, w_update;
  logic [N-1:0]    w_new;

  function automatic logic [KW-1:0] lowest_idx(input logic [N-1:0] v);
    logic [KW-1:0] idx;
    idx = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (v[i]) idx = KW'(i);
    end
    return idx;
  endfunction

  function automatic logic many_bits(input logic [N-1:0] v);
    return |(v & (v - N'(1)));
  endfunction

  assign w_term = (r_presc == PW'(SCAN_DIV-1));
  assign w_new  = r_snap & ~r_key_map;

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_SCAN;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_row_nxt   = r_row;
    case (r_state)
      ST_SCAN: begin
        if (w_term) begin
          w_presc_nxt = '0;
          if (r_row == RW'(ROWS-1)) begin
            w_row_nxt   = '0;
            w_state_nxt = ST_EVAL;
          end else begin
            w_row_nxt = r_row + RW'(1);
          end
        end else begin
          w_presc_nxt = r_presc + PW'(1);
        end
      end
      ST_EVAL: begin
        w_presc_nxt = '0;
        w_row_nxt   = '0;
        w_state_nxt = ST_SCAN;
      end
      default: begin
        w_presc_nxt = '0;
        w_row_nxt   = '0;
        w_state_nxt = ST_SCAN;
      end
    endcase
  end

  // Debounce: a fresh mismatch restarts the count at one, i.e. this scan is the first of a new run
  always_comb begin
    w_stable_nxt = SW'(1);
    if (r_snap == r_prev) begin
      if (r_stable >= SW'(DEB_CNT)) w_stable_nxt = SW'(DEB_CNT);
      else                          w_stable_nxt = r_stable + SW'(1);
    end else begin
      w_stable_nxt = SW'(1);
    end
    w_update = (r_state == ST_EVAL) && (w_stable_nxt >= SW'(DEB_CNT)) && (r_snap != r_key_map);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_presc     <= '0;
      r_row       <= '0;
      r_row_o     <= ~ROWS'(1);
      r_col_m     <= '1;
      r_col_s     <= '1;
      r_snap      <= '0;
      r_prev      <= '0;
      r_stable    <= '0;
      r_key_map   <= '0;
      r_key_code  <= '0;
      r_key_press <= 1'b0;
      r_key_any   <= 1'b0;
      r_key_multi <= 1'b0;
    end else begin
      r_col_m     <= col_i;
      r_col_s     <= r_col_m;
      r_presc     <= w_presc_nxt;
      r_row       <= w_row_nxt;
      r_row_o     <= ~(ROWS'(1) << w_row_nxt);
      r_key_press <= 1'b0;
      r_key_multi <= 1'b0;
      if (r_state == ST_SCAN && w_term) r_snap[r_row*COLS +: COLS] <= ~r_col_s;
      if (r_state == ST_EVAL) begin
        r_prev   <= r_snap;
        r_stable <= w_stable_nxt;
      end
      if (w_update) begin
        r_key_map <= r_snap;
        r_key_any <= |r_snap;
        if (|w_new) begin
          r_key_press <= 1'b1;
          r_key_code  <= lowest_idx(w_new);
          r_key_multi <= many_bits(w_new);
        end
      end
    end
  end

`ifdef NF_KEYPAD_RELEASE_EN
  logic [N-1:0]  w_rel;
  logic          r_key_release;
  logic [KW-1:0] r_key_rel_code;

  assign w_rel = r_key_map & ~r_snap;

  // Release strobe shares the key_map update edge
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_key_release  <= 1'b0;
      r_key_rel_code <= '0;
    end else begin
      r_key_release <= 1'b0;
      if (w_update && |w_rel) begin
        r_key_release  <= 1'b1;
        r_key_rel_code <= lowest_idx(w_rel);
      end
    end
  end

  assign key_release  = r_key_release;
  assign key_rel_code = r_key_rel_code;
`endif

  assign row_o     = r_row_o;
  assign key_map   = r_key_map;
  assign key_code  = r_key_code;
  assign key_press = r_key_press;
  assign key_any   = r_key_any;
  assign key_multi = r_key_multi;

endmodule

// File: tb/tb_nf_keypad_scan.sv
// Scoreboard bench for nf_keypad_scan: a keypad model drives col_i, expected presses are queued and compared on key_press.
module tb_nf_keypad_scan;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int PER  = 17;  // full scan plus EVAL cycle

  logic        clk;
  logic        resetn;
  logic [3:0]  row_o;
  logic [3:0]  col_i;
  logic [15:0] key_map;
  logic [3:0]  key_code;
  logic        key_press, key_any, key_multi;
`ifdef NF_KEYPAD_RELEASE_EN
  logic        key_release;
  logic [3:0]  key_rel_code;
  int          rel_cnt;
  int          rel_last;
`endif

  logic [15:0] keys;
  int          n_vec, n_err;

  typedef struct {int code; int multi; int map;} exp_t;
  exp_t sb_q[$];

  nf_keypad_scan #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEB_CNT(2)) dut (
    .clk(clk), .resetn(resetn), .row_o(row_o), .col_i(col_i),
    .key_map(key_map), .key_code(key_code), .key_press(key_press),
    .key_any(key_any), .key_multi(key_multi)
`ifdef NF_KEYPAD_RELEASE_EN
    , .key_release(key_release), .key_rel_code(key_rel_code)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive keypad: a pressed key shorts its column to a driven-low row
  always_comb begin
    col_i = 4'hF;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row_o[r] && keys[r*COLS+c]) col_i[c] = 1'b0;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_row(input int n);
    int r, q;
    logic [3:0] v;
    if (n < 16) r = n / 4;
    else begin
      q = (n - 16) % PER;
      r = (q == 0) ? 0 : (q - 1) / 4;
    end
    v = 4'b0001 << r;
    return ~v;
  endfunction

  task automatic push_exp(input int code, input int multi, input int map);
    exp_t e;
    e.code = code; e.multi = multi; e.map = map;
    sb_q.push_back(e);
  endtask

  task automatic wait_scans(input int n);
    repeat (n*PER) @(negedge clk);
  endtask

  task automatic wait_row(input logic [3:0] pat);
    int k;
    k = 0;
    while (row_o != pat && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq("wait_row", {28'h0, row_o}, {28'h0, pat});
  endtask

  always @(negedge clk) begin
    if (key_press) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_press", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("key_code", {28'h0, key_code}, e.code);
        check_eq("key_multi", {31'h0, key_multi}, e.multi);
        check_eq("key_map@press", {16'h0, key_map}, e.map);
        check_eq("key_any@press", {31'h0, key_any}, {31'h0, (e.map != 0)});
      end
    end else if (key_multi) begin
      check_eq("multi_idle", 32'd1, 32'd0);
    end
`ifdef NF_KEYPAD_RELEASE_EN
    if (key_release) begin
      rel_cnt++;
      rel_last = key_rel_code;
    end
`endif
  end

  initial begin
    int first;
    n_vec = 0; n_err = 0;
    keys = 16'h0;
    resetn = 1'b0;
`ifdef NF_KEYPAD_RELEASE_EN
    rel_cnt = 0; rel_last = 0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Reset state and idle row sequence
    check_eq("rst_key_map", {16'h0, key_map}, 32'h0);
    check_eq("rst_key_code", {28'h0, key_code}, 32'h0);
    check_eq("rst_key_press", {31'h0, key_press}, 32'h0);
    check_eq("rst_key_any", {31'h0, key_any}, 32'h0);
    check_eq("rst_key_multi", {31'h0, key_multi}, 32'h0);
    for (int n = 0; n < 40; n++) begin
      check_eq("row_seq", {28'h0, row_o}, {28'h0, exp_row(n)});
      @(negedge clk);
    end
    check_eq("idle_map", {16'h0, key_map}, 32'h0);

    // Key 9 present in exactly one snapshot
    wait_row(4'b1101);
    keys = 16'h0200;
    wait_row(4'b0111);
    repeat (3) @(negedge clk);
    keys = 16'h0000;
    wait_scans(4);
    check_eq("glitch_map", {16'h0, key_map}, 32'h0);

    // Hold key 9
    push_exp(9, 0, 32'h0200);
    keys = 16'h0200;
    wait_scans(6);
    check_eq("press9_seen", sb_q.size(), 32'd0);
    check_eq("hold_map", {16'h0, key_map}, 32'h0200);
    check_eq("hold_any", {31'h0, key_any}, 32'h1);

    // Reset mid-scan with key 9 held: re-reported 2 scans later
    push_exp(9, 0, 32'h0200);
    wait_row(4'b1011);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check_eq("mrst_row", {28'h0, row_o}, 32'he);
    check_eq("mrst_map", {16'h0, key_map}, 32'h0);
    check_eq("mrst_any", {31'h0, key_any}, 32'h0);
    check_eq("mrst_code", {28'h0, key_code}, 32'h0);
    first = -1;
    for (int n = 0; n < 50; n++) begin
      if (key_press && first < 0) first = n;
      @(negedge clk);
    end
    check_eq("press_latency", first, 32'd34);
    check_eq("repress_seen", sb_q.size(), 32'd0);
    check_eq("repress_map", {16'h0, key_map}, 32'h0200);

    // Release key 9
`ifdef NF_KEYPAD_RELEASE_EN
    rel_cnt = 0;
`endif
    keys = 16'h0000;
    wait_scans(6);
    check_eq("release_map", {16'h0, key_map}, 32'h0);
    check_eq("release_any", {31'h0, key_any}, 32'h0);
`ifdef NF_KEYPAD_RELEASE_EN
    check_eq("rel_count", rel_cnt, 32'd1);
    check_eq("rel_code", rel_last, 32'd9);
`endif

    // Keys 5 and 12 together
    push_exp(5, 1, 32'h1020);
    keys = 16'h1020;
    wait_scans(6);
    check_eq("multi_seen", sb_q.size(), 32'd0);
    check_eq("multi_map", {16'h0, key_map}, 32'h1020);
    check_eq("multi_any", {31'h0, key_any}, 32'h1);

    // Key 3 added while 5 and 12 stay held: only key 3 is new
    push_exp(3, 0, 32'h1028);
    keys = 16'h1028;
    wait_scans(6);
    check_eq("add_seen", sb_q.size(), 32'd0);
    check_eq("add_map", {16'h0, key_map}, 32'h1028);
    check_eq("add_code_hold", {28'h0, key_code}, 32'h3);

    keys = 16'h0000;
    wait_scans(6);
    check_eq("final_map", {16'h0, key_map}, 32'h0);
    check_eq("final_queue", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
